// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready handshake bundle for pipe_stage_elastic: upstream (in_*) and downstream (out_*) sides.
interface pipe_stage_elastic_if #(
  parameter int unsigned DATA_W = 48
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // Stage view: consumes upstream offers, produces downstream payloads.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  // Environment view: drives upstream offers and downstream ready.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Two-entry elastic pipeline stage (main + skid register) with registered backpressure.
// in_ready is a decode of held state only, so there is no out_ready -> in_ready path.
// Optional stall counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_elastic #(
  parameter int unsigned       DATA_W   = 48,
  parameter logic [DATA_W-1:0] FILL_VAL = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_stage_elastic_if.slave  bus,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);

  // State encoding doubles as {skid_valid, main_valid}; 2'b10 is unreachable.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              main_valid;
  logic              skid_valid;
  logic              acc;
  logic              pop;

  assign main_valid = state_q[0];
  assign skid_valid = state_q[1];

  assign bus.in_ready  = ~skid_valid & ~rst;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_q;
  assign occupancy     = {1'b0, main_valid} + {1'b0, skid_valid};

  assign acc = bus.in_valid & bus.in_ready;
  assign pop = main_valid & bus.out_ready;

  // Next-state and data-path selection; flush overrides all transitions.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_d = ST_ONE;
          main_d  = bus.in_data;
        end
      end
      ST_ONE: begin
        if (acc && pop) begin
          main_d  = bus.in_data;
        end else if (acc) begin
          state_d = ST_FULL;
          skid_d  = bus.in_data;
        end else if (pop) begin
          state_d = ST_EMPTY;
          main_d  = FILL_VAL;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_ONE;
          main_d  = skid_q;
          skid_d  = FILL_VAL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        main_d  = FILL_VAL;
        skid_d  = FILL_VAL;
      end
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = FILL_VAL;
      skid_d  = FILL_VAL;
    end
  end

  // State and entry registers with synchronous reset to the fill value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= FILL_VAL;
      skid_q  <= FILL_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  // Saturating count of cycles where a valid output is held back; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (main_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

  // A skid entry without a main entry would break ordering.
  a_skid_implies_main: assert property (@(posedge clk) disable iff (rst) !(skid_valid && !main_valid))
    else $error("pipe_stage_elastic: skid valid while main invalid");

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed, table-driven bench for pipe_stage_elastic (DATA_W=12, FILL_VAL=12'hF00, CNT_W=2).
module tb_pipe_stage_elastic;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned CNT_W  = 2;
  localparam logic [DATA_W-1:0] FILL = 12'hF00;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_elastic_if #(.DATA_W(DATA_W)) bus ();

  pipe_stage_elastic #(
    .DATA_W   (DATA_W),
    .FILL_VAL (FILL),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;
    logic              exp_out_valid;
    logic [DATA_W-1:0] exp_out_data;
    logic              exp_in_ready;
    logic [1:0]        exp_occ;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic iv, input logic [DATA_W-1:0] d,
                     input logic ordy, input logic eov, input logic [DATA_W-1:0] eod,
                     input logic eir, input logic [1:0] eocc);
    vec_t v;
    v.rst = r; v.flush = f; v.in_valid = iv; v.in_data = d; v.out_ready = ordy;
    v.exp_out_valid = eov; v.exp_out_data = eod; v.exp_in_ready = eir; v.exp_occ = eocc;
    vecs.push_back(v);
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic r, input logic f, input logic iv, input logic [DATA_W-1:0] d,
                      input logic ordy);
    @(negedge clk);
    rst = r; flush = f; bus.in_valid = iv; bus.in_data = d; bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  logic [CNT_W-1:0] exp_sat;

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    //   rst flush iv data     ordy | ov  data     ir  occ
    // Reset then idle
    add(1, 0, 0, 12'h000, 0,   0, FILL,    0, 2'd0);
    add(1, 0, 0, 12'h000, 0,   0, FILL,    0, 2'd0);
    add(0, 0, 0, 12'h000, 0,   0, FILL,    1, 2'd0);
    // Streaming at full rate
    add(0, 0, 1, 12'h001, 1,   1, 12'h001, 1, 2'd1);
    add(0, 0, 1, 12'h002, 1,   1, 12'h002, 1, 2'd1);
    add(0, 0, 1, 12'h003, 1,   1, 12'h003, 1, 2'd1);
    add(0, 0, 1, 12'h004, 1,   1, 12'h004, 1, 2'd1);
    add(0, 0, 1, 12'h005, 1,   1, 12'h005, 1, 2'd1);
    add(0, 0, 0, 12'h000, 1,   0, FILL,    1, 2'd0);
    // Backpressure fills skid; offer while full is refused
    add(0, 0, 1, 12'h0AA, 0,   1, 12'h0AA, 1, 2'd1);
    add(0, 0, 1, 12'h0BB, 0,   1, 12'h0AA, 0, 2'd2);
    add(0, 0, 1, 12'h0DD, 0,   1, 12'h0AA, 0, 2'd2);
    add(0, 0, 0, 12'h000, 1,   1, 12'h0BB, 1, 2'd1);
    add(0, 0, 0, 12'h000, 1,   0, FILL,    1, 2'd0);
    // Flush while full with a concurrent offer
    add(0, 0, 1, 12'h0A1, 0,   1, 12'h0A1, 1, 2'd1);
    add(0, 0, 1, 12'h0A2, 0,   1, 12'h0A1, 0, 2'd2);
    add(0, 1, 1, 12'h0CC, 0,   0, FILL,    1, 2'd0);
    add(0, 0, 0, 12'h000, 1,   0, FILL,    1, 2'd0);
    // Flush in ONE drops an offer even though in_ready=1
    add(0, 0, 1, 12'h0B1, 0,   1, 12'h0B1, 1, 2'd1);
    add(0, 1, 1, 12'h0CC, 1,   0, FILL,    1, 2'd0);
    add(0, 0, 0, 12'h000, 1,   0, FILL,    1, 2'd0);
    // Simultaneous accept and pop in ONE
    add(0, 0, 1, 12'h011, 0,   1, 12'h011, 1, 2'd1);
    add(0, 0, 1, 12'h022, 1,   1, 12'h022, 1, 2'd1);
    add(0, 0, 0, 12'h000, 1,   0, FILL,    1, 2'd0);
    // Pop from FULL with an offer pending: offer not taken that edge
    add(0, 0, 1, 12'h031, 0,   1, 12'h031, 1, 2'd1);
    add(0, 0, 1, 12'h032, 0,   1, 12'h031, 0, 2'd2);
    add(0, 0, 1, 12'h033, 1,   1, 12'h032, 1, 2'd1);
    add(0, 0, 1, 12'h033, 1,   1, 12'h033, 1, 2'd1);
    add(0, 0, 0, 12'h000, 1,   0, FILL,    1, 2'd0);
    // Reset mid-stall discards both entries
    add(0, 0, 1, 12'h041, 0,   1, 12'h041, 1, 2'd1);
    add(0, 0, 1, 12'h042, 0,   1, 12'h041, 0, 2'd2);
    add(1, 0, 1, 12'h043, 0,   0, FILL,    0, 2'd0);
    add(0, 0, 0, 12'h000, 0,   0, FILL,    1, 2'd0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].flush, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
      check($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_out_valid));
      check($sformatf("v%0d out_data", i),  32'(bus.out_data),  32'(vecs[i].exp_out_data));
      check($sformatf("v%0d in_ready", i),  32'(bus.in_ready),  32'(vecs[i].exp_in_ready));
      check($sformatf("v%0d occupancy", i), 32'(occupancy),     32'(vecs[i].exp_occ));
    end

    // Stall counter: saturation, survives flush, cleared by rst
`ifdef PIPE_STAGE_STALL_CNT_EN
    exp_sat = 2'd3;
`else
    exp_sat = 2'd0;
`endif
    step(1, 0, 0, 12'h000, 0);
    check("stall after rst", 32'(stall_cnt), 32'd0);
    step(0, 0, 1, 12'h055, 0);
    check("stall first load", 32'(stall_cnt), 32'd0);
    step(0, 0, 0, 12'h000, 0);
    step(0, 0, 0, 12'h000, 0);
`ifdef PIPE_STAGE_STALL_CNT_EN
    check("stall two cycles", 32'(stall_cnt), 32'd2);
`else
    check("stall two cycles", 32'(stall_cnt), 32'd0);
`endif
    step(0, 0, 0, 12'h000, 0);
    step(0, 0, 0, 12'h000, 0);
    step(0, 0, 0, 12'h000, 0);
    check("stall saturated", 32'(stall_cnt), 32'(exp_sat));
    check("stall hold data", 32'(bus.out_data), 32'(12'h055));
    step(0, 1, 0, 12'h000, 0);
    check("stall after flush", 32'(stall_cnt), 32'(exp_sat));
    check("flush empties", 32'(bus.out_valid), 32'd0);
    step(1, 0, 0, 12'h000, 0);
    check("stall cleared by rst", 32'(stall_cnt), 32'd0);
    step(0, 0, 0, 12'h000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
